// File: rtl/layer_serializer.sv
// layer_serializer: captures one NN-word frame of neuron outputs and streams it one word per transfer.
// Latency: the first word is valid 1 cycle after the frame event; frame_done pulses 1 cycle after the last transfer.
// Backpressure: out_ready low holds out_data and the word index. A frame arriving mid-send is dropped and sets overrun.
//
// Ports:
//   clk, rst          single clock, asynchronous active-high reset
//   in_valid[NN]      per-word valid; a frame event is all bits high in one cycle
//   in_data           NN packed words, word i at [i*dataWidth +: dataWidth]
//   out_ready         downstream accepts out_data this cycle
//   clr_overrun       synchronous clear of the sticky overrun flag
//   out_data/out_valid serialized word stream, word 0 first
//   busy              a frame is held or being sent
//   frame_done        one-cycle pulse after the final word is accepted
//   overrun           sticky: a frame was dropped because one was in progress
module layer_serializer #(
    parameter int NN        = 10,
    parameter int dataWidth = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NN-1:0]           in_valid,
    input  logic [NN*dataWidth-1:0] in_data,
    input  logic                    out_ready,
    input  logic                    clr_overrun,
    output logic [dataWidth-1:0]    out_data,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    overrun
);

    localparam int IW = $clog2(NN);
    localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [dataWidth-1:0]   buf_q [NN];
    logic                   frame_done_q, frame_done_d;
    logic                   overrun_q, overrun_d;
    logic                   load;

    logic frame_evt;
    logic xfer;
    logic final_xfer;

    assign frame_evt  = &in_valid;
    assign xfer       = (state_q == SEND) && out_ready;
    assign final_xfer = xfer && (idx_q == LAST_IDX);

    // Next-state and control.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        load         = 1'b0;
        frame_done_d = final_xfer;
        overrun_d    = overrun_q;

        case (state_q)
            IDLE: begin
                if (frame_evt) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (final_xfer) begin
                    idx_d = '0;
                    // A frame landing on the final transfer is taken back-to-back,
                    // so the stream continues without a gap.
                    if (frame_evt) begin
                        load    = 1'b1;
                        state_d = SEND;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (xfer) begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase

        // Set has priority over clear.
        if (state_q == SEND && frame_evt && !final_xfer) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NN; i++) begin
                buf_q[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < NN; i++) begin
                buf_q[i] <= in_data[i*dataWidth +: dataWidth];
            end
        end
    end

    assign out_data   = buf_q[idx_q];
    assign out_valid  = (state_q == SEND);
    assign busy       = (state_q == SEND);
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_layer_serializer.sv
// Directed testbench for layer_serializer with NN=10, dataWidth=16.
// Inputs change 1 time unit after the rising edge; outputs are checked at that point too.
module tb_layer_serializer;

    localparam int NN = 10;
    localparam int DW = 16;

    logic               clk;
    logic               rst;
    logic [NN-1:0]      in_valid;
    logic [NN*DW-1:0]   in_data;
    logic               out_ready;
    logic               clr_overrun;
    logic [DW-1:0]      out_data;
    logic               out_valid;
    logic               busy;
    logic               frame_done;
    logic               overrun;

    int checks = 0;
    int errors = 0;

    layer_serializer #(.NN(NN), .dataWidth(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_ready   (out_ready),
        .clr_overrun (clr_overrun),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NN*DW-1:0] frame(input logic [DW-1:0] base);
        logic [NN*DW-1:0] d;
        d = '0;
        for (int i = 0; i < NN; i++) begin
            d[i*DW +: DW] = base + DW'(i);
        end
        return d;
    endfunction

    initial begin
        int cnt;
        rst         = 1'b1;
        in_valid    = '0;
        in_data     = '0;
        out_ready   = 1'b0;
        clr_overrun = 1'b0;
        tick();
        tick();

        // Reset state.
        chk("rst_out_valid",  {31'd0, out_valid},  32'd0);
        chk("rst_busy",       {31'd0, busy},       32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_overrun",    {31'd0, overrun},    32'd0);
        chk("rst_out_data",   {16'd0, out_data},   32'd0);
        rst = 1'b0;
        tick();

        // Full frame with out_ready held high.
        in_valid  = '1;
        in_data   = frame(16'h0100);
        out_ready = 1'b1;
        tick();
        in_valid = '0;
        for (int k = 0; k < NN; k++) begin
            chk("f1_valid", {31'd0, out_valid}, 32'd1);
            chk("f1_data",  {16'd0, out_data},  32'h0100 + k);
            chk("f1_done",  {31'd0, frame_done}, 32'd0);
            tick();
        end
        chk("f1_valid_drop", {31'd0, out_valid},  32'd0);
        chk("f1_done_pulse", {31'd0, frame_done}, 32'd1);
        chk("f1_busy_idle",  {31'd0, busy},       32'd0);
        tick();
        chk("f1_done_end",   {31'd0, frame_done}, 32'd0);

        // out_ready toggling 1,0,1,0...
        in_valid = '1;
        in_data  = frame(16'h0200);
        tick();
        in_valid = '0;
        cnt = 0;
        for (int c = 0; c < 40 && cnt < NN; c++) begin
            out_ready = (c % 2 == 0);
            chk("f2_valid", {31'd0, out_valid},  32'd1);
            chk("f2_data",  {16'd0, out_data},   32'h0200 + cnt);
            chk("f2_done",  {31'd0, frame_done}, 32'd0);
            if (out_ready) cnt++;
            tick();
        end
        chk("f2_count",      cnt, NN);
        chk("f2_done_pulse", {31'd0, frame_done}, 32'd1);
        chk("f2_valid_drop", {31'd0, out_valid},  32'd0);
        out_ready = 1'b1;
        tick();
        chk("f2_done_once",  {31'd0, frame_done}, 32'd0);

        // Second frame arriving at transfer 5 is dropped and sets overrun.
        in_valid = '1;
        in_data  = frame(16'h0300);
        tick();
        for (int k = 0; k < NN; k++) begin
            chk("f3_data",    {16'd0, out_data}, 32'h0300 + k);
            chk("f3_overrun", {31'd0, overrun},  (k > 5) ? 32'd1 : 32'd0);
            if (k == 5) begin
                in_valid = '1;
                in_data  = frame(16'hAA00);
            end else begin
                in_valid = '0;
            end
            tick();
        end
        chk("f3_done_pulse", {31'd0, frame_done}, 32'd1);
        chk("f3_overrun_hold", {31'd0, overrun},  32'd1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk("f3_overrun_clr", {31'd0, overrun},   32'd0);

        // Frame event coincident with the final transfer: back-to-back capture.
        in_valid = '1;
        in_data  = frame(16'h0400);
        tick();
        for (int k = 0; k < NN; k++) begin
            chk("f4_valid", {31'd0, out_valid}, 32'd1);
            chk("f4_data",  {16'd0, out_data},  32'h0400 + k);
            if (k == 9) begin
                in_valid = '1;
                in_data  = frame(16'h0500);
            end else begin
                in_valid = '0;
            end
            tick();
        end
        in_valid = '0;
        chk("b2b_valid",   {31'd0, out_valid},  32'd1);
        chk("b2b_data0",   {16'd0, out_data},   32'h0500);
        chk("b2b_done",    {31'd0, frame_done}, 32'd1);
        chk("b2b_overrun", {31'd0, overrun},    32'd0);
        chk("b2b_busy",    {31'd0, busy},       32'd1);
        for (int k = 1; k < NN; k++) begin
            tick();
            chk("b2b_data", {16'd0, out_data}, 32'h0500 + k);
            chk("b2b_done_low", {31'd0, frame_done}, 32'd0);
        end
        tick();
        chk("b2b_end_done",  {31'd0, frame_done}, 32'd1);
        chk("b2b_end_valid", {31'd0, out_valid},  32'd0);
        tick();

        // Partial in_valid is ignored.
        in_valid = 10'h3FE;
        in_data  = frame(16'h0900);
        tick();
        in_valid = '0;
        chk("partial_busy",  {31'd0, busy},      32'd0);
        chk("partial_valid", {31'd0, out_valid}, 32'd0);
        tick();

        // Reset mid-frame after 4 transfers.
        in_valid = '1;
        in_data  = frame(16'h0600);
        tick();
        in_valid = '0;
        for (int k = 0; k < 4; k++) tick();
        chk("mid_data", {16'd0, out_data}, 32'h0604);
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, out_valid},  32'd0);
        chk("arst_busy",  {31'd0, busy},       32'd0);
        chk("arst_data",  {16'd0, out_data},   32'd0);
        chk("arst_done",  {31'd0, frame_done}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_done",  {31'd0, frame_done}, 32'd0);
        chk("post_rst_valid", {31'd0, out_valid},  32'd0);
        in_valid = '1;
        in_data  = frame(16'h0700);
        tick();
        in_valid = '0;
        for (int k = 0; k < NN; k++) begin
            chk("f7_data", {16'd0, out_data}, 32'h0700 + k);
            tick();
        end
        chk("f7_done", {31'd0, frame_done}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/layer_serializer.md
LAYER_SERIALIZER -- requirements
Module: layer_serializer

Interface
REQ-001 Parameter NN, default 10, number of neuron outputs in one frame (2..64).
REQ-002 Parameter dataWidth, default 16, width of one neuron output word.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  NN  per-neuron output-valid bits; bit i belongs to word i.
REQ-006 in_data  input  NN*dataWidth  packed neuron outputs; word i = in_data[i*dataWidth +: dataWidth].
REQ-007 out_ready  input  1  downstream accepts out_data this cycle.
REQ-008 clr_overrun  input  1  synchronous clear of overrun.
REQ-009 out_data  output  dataWidth  current serialized word, same format as the next layer's single-word input.
REQ-010 out_valid  output  1  out_data holds a valid word.
REQ-011 busy  output  1  high while a frame is held or being sent.
REQ-012 frame_done  output  1  one-cycle pulse after the last word of a frame is accepted.
REQ-013 overrun  output  1  sticky flag: a frame arrived while a frame was in progress and was dropped.

Function
REQ-014 The block SHALL have two states: IDLE and SEND.
REQ-015 A frame event SHALL be the cycle in which all NN bits of in_valid are 1; partial in_valid patterns SHALL be ignored.
REQ-016 In IDLE, a frame event SHALL capture all NN words into an internal NN x dataWidth buffer, clear the word index to 0, and enter SEND.
REQ-017 out_valid SHALL be high from the cycle after capture, with out_data = buffered word 0; latency from the frame event to the first out_valid is 1 cycle.
REQ-018 In SEND, out_data SHALL equal buffered word[index]; a word transfers only in a cycle with out_valid and out_ready both high.
REQ-019 On each transfer the index SHALL increment by 1; without out_ready, out_data and the index SHALL hold unchanged (no word skipped or repeated).
REQ-020 The word index SHALL be $clog2(NN) bits wide and SHALL never exceed NN-1.
REQ-021 A transfer at index NN-1 SHALL return to IDLE, drop out_valid in the next cycle, and assert frame_done for exactly that next cycle.
REQ-022 A frame event in SEND, in any cycle other than the final transfer, SHALL be dropped, SHALL leave the buffer unchanged, and SHALL set overrun.
REQ-023 A frame event in the same cycle as the final transfer (index NN-1, out_ready high) SHALL be captured back-to-back: the index resets to 0 and the state stays SEND.
REQ-024 In the back-to-back case, out_valid SHALL stay high, frame_done SHALL still pulse, and overrun SHALL not be set.
REQ-025 busy SHALL equal (state == SEND).
REQ-026 clr_overrun SHALL clear overrun the next cycle; if a dropping frame event occurs in the same cycle, set SHALL win.
REQ-027 Buffered data SHALL pass through bit-exact, with no sign extension, rounding or reordering; word 0 is emitted first.

Reset
REQ-028 While rst is high, the block SHALL hold state IDLE, index 0, out_valid 0, busy 0, frame_done 0 and overrun 0.
REQ-029 out_data and the buffer SHALL reset to 0.
REQ-030 Asserting rst mid-frame SHALL abort the frame immediately, with no frame_done; the remaining words are discarded.
REQ-031 After rst deasserts, the first frame event SHALL be handled as in IDLE.

Verification
REQ-032 NN=10, out_ready held 1, frame event with word i = 16'h0100+i -> out_valid high for cycles 1..10 after the event, emitting 0100..0109 in order; frame_done pulses in cycle 11.
REQ-033 Same frame with out_ready toggling 1,0,1,0... -> exactly 10 transfers in order; out_data stable while out_ready is 0; frame_done pulses once.
REQ-034 Second frame event at transfer 5 -> overrun=1; the first frame completes unchanged; clr_overrun then returns overrun to 0.
REQ-035 Second frame event coincident with the transfer of word 9 -> out_valid never drops; next word = the new word 0; frame_done pulses; overrun stays 0.
REQ-036 in_valid = 10'h3FE (bit 0 low) in IDLE -> no capture; busy stays 0.
REQ-037 rst pulsed after 4 transfers -> all outputs reset within the same cycle; no frame_done; a following frame is sent from word 0.
